// File: rtl/alu_serial_seq_if.sv
// Request/result bundle for the bit-serial ALU sequencer.
// The master side issues operations; the slave side is the sequencer.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b, alu_control,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, a, b, alu_control,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds one 1-bit ALU slice LSB first, registering carry,
// and assembles a WIDTH-bit result with zero/overflow flags behind a start/done handshake.
module alu_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [3:0] op,
  output logic       res,
  output logic       cout
);
  logic aa, bb;

  // op[3] inverts A, op[2] inverts B, op[1:0] selects AND/OR/SUM/LESS
  always_comb begin
    aa   = a ^ op[3];
    bb   = b ^ op[2];
    cout = (aa & bb) | (cin & (aa ^ bb));
    res  = 1'b0;
    case (op[1:0])
      2'b00:   res = aa & bb;
      2'b01:   res = aa | bb;
      2'b10:   res = aa ^ bb ^ cin;
      default: res = less;
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_serial_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] SLT_FIX = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [3:0]       op_q,     op_d;
  logic [WIDTH-1:0] sh_q,     sh_d;
  logic             set_q,    set_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;

  logic       s_res, s_cout;
  logic [3:0] s_op;
  logic       accept, last, ovf_w, op_ok, is_addsub;

  alu_1bit alu_i (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .less (1'b0),
    .op   (s_op),
    .res  (s_res),
    .cout (s_cout)
  );

  always_comb begin
    s_op      = (op_q == OP_SLT) ? OP_SUB : op_q;
    accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
    last      = (cnt_q == CW'(WIDTH - 1));
    ovf_w     = carry_q ^ s_cout;
    op_ok     = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_NOR);
    is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);

    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sh_d     = sh_q;
    set_d    = set_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      RUN: begin
        // Operands shift right so the slice always sees bit 0
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {s_res, sh_q[WIDTH-1:1]};
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          if (op_q == OP_SLT) begin
            set_d   = s_res ^ ovf_w;
            state_d = SLT_FIX;
          end else begin
            result_d = op_ok ? sh_d : '0;
            zero_d   = op_ok ? ~|sh_d : 1'b1;
            ovf_d    = is_addsub & ovf_w;
            state_d  = DONE;
          end
        end
      end
      SLT_FIX: begin
        sh_d     = {{(WIDTH-1){1'b0}}, set_q};
        result_d = sh_d;
        zero_d   = ~set_q;
        ovf_d    = 1'b0;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Acceptance overrides the DONE -> IDLE transition for back-to-back requests
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      op_d    = bus.alu_control;
      cnt_d   = '0;
      carry_d = (bus.alu_control == OP_SUB) || (bus.alu_control == OP_SLT);
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      set_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      set_q    <= set_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN) || (state_q == SLT_FIX);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed vector table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_serial_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();
  alu_serial_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Returns {overflow, zero, result} from plain two's-complement arithmetic
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         v;
    r = '0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, (r == '0), r};
  endfunction

  // Called at a falling edge; returns in the cycle after the accept edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start       = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.alu_control = op;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycle count is relative to the accept cycle (cycle 0)
  task automatic wait_done(input int start_cyc, output int lat, output bit held);
    logic [W-1:0] r0;
    logic         z0, v0;
    r0   = bus.result;
    z0   = bus.zero;
    v0   = bus.overflow;
    lat  = start_cyc;
    held = 1'b1;
    while (!bus.done && lat < 80) begin
      if (bus.result !== r0 || bus.zero !== z0 || bus.overflow !== v0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_done(input string name, input logic [W-1:0] res, input logic zero,
                            input logic ovf, input int lat_exp, input int lat, input bit held);
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_hold"}, held, 1'b1);
    check({name, "_result"}, bus.result, res);
    check({name, "_zero"}, bus.zero, zero);
    check({name, "_overflow"}, bus.overflow, ovf);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit held;
    issue(v.op, v.a, v.b);
    check({v.name, "_busy"}, bus.busy, 1'b1);
    wait_done(1, lat, held);
    check_done(v.name, v.res, v.zero, v.ovf, v.lat, lat, held);
    @(negedge clk);
    check({v.name, "_done_pulse"}, bus.done, 1'b0);
    check({v.name, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic run_model(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    vec_t         v;
    logic [W+1:0] m;
    m      = model(op, a, b);
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.res  = m[W-1:0];
    v.zero = m[W];
    v.ovf  = m[W+1];
    v.lat  = (op == 4'b0111) ? W + 2 : W + 1;
    run_vec(v);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W+1:0] m1, m2;
    logic [3:0]   ops[6];
    logic [3:0]   op;
    int           lat;
    bit           held;
    bit           quiet;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    vecs[0] = '{"add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 33};
    vecs[1] = '{"sub_zero",  4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 33};
    vecs[2] = '{"sub_ovf",   4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 33};
    vecs[3] = '{"slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 34};
    vecs[4] = '{"slt_fix",   4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 34};
    vecs[5] = '{"and",       4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 33};
    vecs[6] = '{"or",        4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 33};
    vecs[7] = '{"nor",       4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0, 1'b0, 33};
    vecs[8] = '{"bad_op",    4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0000, 1'b1, 1'b0, 33};

    bus.start       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.alu_control = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, '0);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Start pulsed mid-operation (bit 5) must be ignored
    m1 = model(4'b0010, 32'h0000_1234, 32'h0000_4321);
    issue(4'b0010, 32'h0000_1234, 32'h0000_4321);
    repeat (5) @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = 32'hDEAD_BEEF;
    bus.b           = 32'h0BAD_F00D;
    bus.alu_control = 4'b0110;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(7, lat, held);
    check_done("ignore_start", m1[W-1:0], m1[W], m1[W+1], 33, lat, held);

    // Back-to-back: start during the done cycle
    m1 = model(4'b0001, 32'h1200_0034, 32'h0056_0000);
    m2 = model(4'b0110, 32'h0000_0010, 32'h0000_0020);
    @(negedge clk);
    issue(4'b0001, 32'h1200_0034, 32'h0056_0000);
    wait_done(1, lat, held);
    check_done("b2b_first", m1[W-1:0], m1[W], m1[W+1], 33, lat, held);
    issue(4'b0110, 32'h0000_0010, 32'h0000_0020);
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_done_low", bus.done, 1'b0);
    check("b2b_prev_held", bus.result, m1[W-1:0]);
    wait_done(1, lat, held);
    check_done("b2b_second", m2[W-1:0], m2[W], m2[W+1], 33, lat, held);
    @(negedge clk);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_model($sformatf("rand%0d", i), op, pick_operand(), pick_operand());
    end

    // Reset mid-operation: leave a non-zero result behind first
    run_model("pre_reset", 4'b0010, 32'h0000_0011, 32'h0000_0022);
    issue(4'b0010, 32'h0000_00FF, 32'h0000_0001);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.result, '0);
    check("abort_zero", bus.zero, 1'b0);
    check("abort_overflow", bus.overflow, 1'b0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_done", quiet, 1'b1);
    vecs[0] = '{"post_reset_add", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 33};
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
